vram_arbiter: RTL and testbench

- Shares the single VRAM QSPI transaction engine between two requesters: the display scan-out reader and the Hack CPU screen-memory port.
- Sits inside hack_soc, between both requesters and the VRAM qspi controller's start/busy/done interface.
- Display has priority. A bounded-run counter guarantees the CPU is granted after at most MAX_DISP_RUN consecutive display transactions while it waits.

---
 rtl/vram_arbiter_if.sv | 50 +++++
 rtl/vram_arbiter.sv | 118 +++++++++++
 tb/tb_vram_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: requester, engine and status signals of vram_arbiter.
// slave = arbiter view, master = surrounding SoC view.
interface vram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) ();
  // Display scan-out requester
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_ack;
  logic [DATA_W-1:0] disp_rdata;
  // CPU screen-memory requester
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  // QSPI transaction engine
  logic              mem_start;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_busy;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  // Status
  logic              owner;
  logic              arb_busy;

  modport slave (
    input  disp_req, disp_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_busy, mem_done, mem_rdata,
    output disp_ack, disp_rdata,
    output cpu_ack, cpu_rdata,
    output mem_start, mem_we, mem_addr, mem_wdata,
    output owner, arb_busy
  );

  modport master (
    output disp_req, disp_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_busy, mem_done, mem_rdata,
    input  disp_ack, disp_rdata,
    input  cpu_ack, cpu_rdata,
    input  mem_start, mem_we, mem_addr, mem_wdata,
    input  owner, arb_busy
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM QSPI engine between display and CPU.
// Ports: clk, reset (sync, active-high), bus (vram_arbiter_if.slave).
module vram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 16,
  parameter int MAX_DISP_RUN = 4
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [3:0] RUN_MAX = 4'(MAX_DISP_RUN);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [3:0] disp_run;
  logic [3:0] run_nx;
  logic       grant;
  logic       grant_cpu;
  logic       done_rd;

  // Display wins contention until it has taken RUN_MAX
  // grants in a row while the CPU was waiting.
  always_comb begin
    grant     = 1'b0;
    grant_cpu = 1'b0;
    if (state == IDLE) begin
      unique case (1'b1)
        bus.disp_req && bus.cpu_req: begin
          grant     = 1'b1;
          grant_cpu = (disp_run >= RUN_MAX);
        end
        bus.disp_req && !bus.cpu_req: begin
          grant = 1'b1;
        end
        !bus.disp_req && bus.cpu_req: begin
          grant     = 1'b1;
          grant_cpu = 1'b1;
        end
        default: begin
          grant = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    run_nx = disp_run;
    if (grant) begin
      if (grant_cpu || !bus.cpu_req)
        run_nx = 4'd0;
      else if (disp_run < RUN_MAX)
        run_nx = disp_run + 4'd1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (grant) state_nx = ISSUE;
      ISSUE: if (!bus.mem_busy) state_nx = WAIT;
      WAIT:  if (bus.mem_done) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign done_rd = (state == WAIT) && bus.mem_done && !bus.mem_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      disp_run       <= 4'd0;
      bus.disp_ack   <= 1'b0;
      bus.cpu_ack    <= 1'b0;
      bus.disp_rdata <= {DATA_W{1'b0}};
      bus.cpu_rdata  <= {DATA_W{1'b0}};
      bus.mem_start  <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= {ADDR_W{1'b0}};
      bus.mem_wdata  <= {DATA_W{1'b0}};
      bus.owner      <= 1'b0;
      bus.arb_busy   <= 1'b0;
    end else begin
      state        <= state_nx;
      disp_run     <= run_nx;
      // start is registered: it fires in the first WAIT cycle
      bus.mem_start <= (state == ISSUE) && !bus.mem_busy;
      bus.disp_ack  <= (state == WAIT) && bus.mem_done && !bus.owner;
      bus.cpu_ack   <= (state == WAIT) && bus.mem_done && bus.owner;
      bus.arb_busy  <= (state_nx != IDLE);
      if (grant) begin
        bus.owner <= grant_cpu;
        bus.mem_we <= grant_cpu && bus.cpu_we;
        if (grant_cpu) begin
          bus.mem_addr  <= bus.cpu_addr;
          bus.mem_wdata <= bus.cpu_wdata;
        end else begin
          bus.mem_addr  <= bus.disp_addr;
          bus.mem_wdata <= {DATA_W{1'b0}};
        end
      end
      if (done_rd) begin
        if (bus.owner)
          bus.cpu_rdata <= bus.mem_rdata;
        else
          bus.disp_rdata <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter.
// Engine model + arbitration reference model + monitor.
module tb_vram_arbiter;
  localparam int AW   = 13;
  localparam int DW   = 16;
  localparam int MAXR = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_DISP_RUN(MAXR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  logic [DW-1:0] eng_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  // Engine model: done D cycles after start, busy meanwhile.
  int            eng_d = 3;
  bit            eng_rand = 0;
  bit            rnd_busy = 0;
  logic          ext_busy = 0;
  logic          ext_done = 0;
  int            e_cnt = 0;
  logic [AW-1:0] e_addr = '0;
  logic          e_we = 0;

  initial begin
    bus.mem_busy  = 1'b0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        e_cnt = 0;
        bus.mem_done = 1'b0;
      end else begin
        bus.mem_done = ext_done;
        if (e_cnt > 0) begin
          e_cnt--;
          if (e_cnt == 0) begin
            bus.mem_done = 1'b1;
            if (!e_we) bus.mem_rdata = eng_mem[e_addr];
          end
        end
        if (bus.mem_start) begin
          e_addr = bus.mem_addr;
          e_we   = bus.mem_we;
          e_cnt  = eng_rand ? int'($urandom_range(1, 4)) : eng_d;
          if (e_we) eng_mem[e_addr] = bus.mem_wdata;
        end
      end
      bus.mem_busy = (e_cnt > 0) || ext_busy ||
                     (rnd_busy && $urandom_range(0, 2) == 0);
    end
  end

  // Reference model and monitor.
  typedef struct packed {
    logic          own;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } xact_t;

  xact_t         start_q[$];
  logic          grant_log[$];
  bit            m_idle = 1, m_issue = 0, m_es = 0;
  bit            m_wait = 0, m_ea = 0;
  logic          m_own = 0;
  int            m_run = 0;
  logic [DW-1:0] last_disp = '0;
  logic [DW-1:0] last_cpu = '0;
  int            n_starts = 0;

  always @(negedge clk) begin : monitor
    bit    c_idle, c_issue, c_es, c_wait, c_ea;
    bit    gr, gcpu, wnow;
    xact_t t;
    if (reset) begin
      m_idle = 1; m_issue = 0; m_es = 0;
      m_wait = 0; m_ea = 0; m_run = 0;
      last_disp = '0; last_cpu = '0;
      start_q.delete();
    end else begin
      c_idle = m_idle; c_issue = m_issue; c_es = m_es;
      c_wait = m_wait; c_ea = m_ea;
      chk("arb_busy", bus.arb_busy, !c_idle);
      chk("mem_start", bus.mem_start, c_es);
      if (bus.mem_start) begin
        n_starts++;
        if (start_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL start_q: unexpected mem_start at %0t", $time);
        end else begin
          t = start_q.pop_front();
          chk("mem_we", bus.mem_we, t.we);
          chk("mem_addr", bus.mem_addr, t.addr);
          if (t.we) chk("mem_wdata", bus.mem_wdata, t.wdata);
          grant_log.push_back(t.own);
        end
      end
      if (!c_idle) chk("owner", bus.owner, m_own);
      chk("disp_ack", bus.disp_ack, c_ea && !m_own);
      chk("cpu_ack", bus.cpu_ack, c_ea && m_own);
      if (c_ea) begin
        chk("disp_rdata", bus.disp_rdata, last_disp);
        chk("cpu_rdata", bus.cpu_rdata, last_cpu);
      end
      wnow = c_wait || c_es;
      gr = 0;
      gcpu = 0;
      if (c_idle && (bus.disp_req || bus.cpu_req)) begin
        gr = 1;
        if (bus.disp_req && bus.cpu_req) gcpu = (m_run >= MAXR);
        else gcpu = bus.cpu_req;
        if (!gcpu && bus.cpu_req)
          m_run = (m_run + 1 > MAXR) ? MAXR : m_run + 1;
        else
          m_run = 0;
        t.own   = gcpu;
        t.we    = gcpu && bus.cpu_we;
        t.addr  = gcpu ? bus.cpu_addr : bus.disp_addr;
        t.wdata = bus.cpu_wdata;
        start_q.push_back(t);
        m_own = gcpu;
        if (t.we) ref_mem[t.addr] = t.wdata;
        else if (gcpu) last_cpu = ref_mem[t.addr];
        else last_disp = ref_mem[t.addr];
      end
      m_es    = c_issue && !bus.mem_busy;
      m_issue = (c_issue && bus.mem_busy) || gr;
      m_ea    = wnow && bus.mem_done;
      m_wait  = wnow && !bus.mem_done;
      m_idle  = c_ea || (c_idle && !gr);
    end
  end

  // Requester: raise req, wait for ack, return at next posedge+1.
  task automatic do_req(input bit cpu, input bit we,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d,
                        output int lat);
    int t;
    t = 0;
    if (cpu) begin
      bus.cpu_req = 1; bus.cpu_we = we;
      bus.cpu_addr = a; bus.cpu_wdata = d;
    end else begin
      bus.disp_req = 1; bus.disp_addr = a;
    end
    forever begin
      @(negedge clk);
      t++;
      if (cpu ? bus.cpu_ack : bus.disp_ack) break;
      if (t > 300) begin
        tests++;
        fails++;
        $display("FAIL %s_timeout: no ack after %0d cycles",
                 cpu ? "cpu" : "disp", t);
        break;
      end
    end
    lat = t;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_disp_ack"}, bus.disp_ack, 0);
    chk({tag, "_cpu_ack"}, bus.cpu_ack, 0);
    chk({tag, "_disp_rdata"}, bus.disp_rdata, 0);
    chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
    chk({tag, "_mem_start"}, bus.mem_start, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_owner"}, bus.owner, 0);
    chk({tag, "_arb_busy"}, bus.arb_busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit pat [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    int lat, s0, g, t;
    logic [DW-1:0] v;
    for (int i = 0; i < (1 << AW); i++) begin
      v = DW'($urandom);
      eng_mem[i] = v;
      ref_mem[i] = v;
    end
    eng_mem[13'h0123] = 16'hBEEF;
    ref_mem[13'h0123] = 16'hBEEF;
    bus.disp_req = 0; bus.disp_addr = '0;
    bus.cpu_req = 0; bus.cpu_we = 0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;

    // Single display read, D = 3
    s0 = n_starts;
    do_req(0, 0, 13'h0123, '0, lat);
    bus.disp_req = 0;
    chk("t1_starts", n_starts - s0, 1);
    chk("t1_rdata", bus.disp_rdata, 16'hBEEF);
    chk("t1_latency", lat - 1, 2 + 3 + 1);

    // CPU write
    do_req(1, 1, 13'h1FFF, 16'hA5A5, lat);
    bus.cpu_req = 0;
    chk("t2_cpu_rdata", bus.cpu_rdata, 0);
    chk("t2_disp_rdata", bus.disp_rdata, 16'hBEEF);
    chk("t2_mem_content", eng_mem[13'h1FFF], 16'hA5A5);

    // Contention: both held continuously
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int lt;
          do_req(0, 0, 13'($urandom), '0, lt);
        end
        bus.disp_req = 0;
      end
      begin
        for (int i = 0; i < 2; i++) begin
          int lt;
          do_req(1, 1'($urandom), 13'($urandom), 16'($urandom), lt);
        end
        bus.cpu_req = 0;
      end
    join
    chk("cont_count", grant_log.size(), 10);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      chk($sformatf("cont_order_%0d", i), grant_log[i], pat[i]);

    // Engine busy for 5 ISSUE cycles
    s0 = n_starts;
    ext_busy = 1;
    fork
      do_req(1, 0, 13'h0123, '0, lat);
      begin
        repeat (6) begin
          @(negedge clk);
          chk("busy_hold_start", bus.mem_start, 0);
        end
        @(posedge clk);
        #1 ext_busy = 0;
      end
    join
    bus.cpu_req = 0;
    chk("busy_one_start", n_starts - s0, 1);
    chk("busy_cpu_rdata", bus.cpu_rdata, 16'hBEEF);

    // Spurious done while IDLE
    ext_done = 1;
    @(posedge clk);
    #1 ext_done = 0;
    repeat (3) begin
      @(negedge clk);
      chk("spur_arb_busy", bus.arb_busy, 0);
      chk("spur_acks", {bus.disp_ack, bus.cpu_ack}, 0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic
    rnd_busy = 1;
    eng_rand = 1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int lt;
          g = $urandom_range(0, 2);
          if (g > 0) begin
            bus.disp_req = 0;
            repeat (g) @(posedge clk);
            #1;
          end
          do_req(0, 0, 13'($urandom), '0, lt);
        end
        bus.disp_req = 0;
      end
      begin
        for (int i = 0; i < 30; i++) begin
          int lt, gc;
          gc = $urandom_range(0, 3);
          if (gc > 0) begin
            bus.cpu_req = 0;
            repeat (gc) @(posedge clk);
            #1;
          end
          do_req(1, 1'($urandom), 13'($urandom), 16'($urandom), lt);
        end
        bus.cpu_req = 0;
      end
    join
    rnd_busy = 0;
    eng_rand = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset during WAIT
    eng_d = 4;
    bus.disp_req = 1;
    bus.disp_addr = 13'h0456;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.mem_start && t < 50);
    chk("rst_saw_start", bus.mem_start, 1);
    @(posedge clk);
    #1;
    reset = 1;
    bus.disp_req = 0;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check_zero("rst_wait");
    @(posedge clk);
    #1 ext_done = 1;
    @(posedge clk);
    #1 ext_done = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_late_done_acks", {bus.disp_ack, bus.cpu_ack}, 0);
      chk("rst_late_done_busy", bus.arb_busy, 0);
    end
    @(posedge clk);
    #1;
    grant_log.delete();
    do_req(1, 0, 13'h1FFF, '0, lat);
    bus.cpu_req = 0;
    chk("rst_cpu_grants", grant_log.size(), 1);
    if (grant_log.size() > 0)
      chk("rst_cpu_owner", grant_log[0], 1);
    chk("rst_cpu_rdata", bus.cpu_rdata, 16'hA5A5);
    chk("rst_cpu_latency", lat - 1, 2 + 4 + 1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
